// File: rtl/llr_stream_checker_if.sv
// Purpose: reference and DUT LLR word streams feeding the LLR stream checker; lane0 in MSBs.
// Latency: none, wires only.
// Backpressure: ref stream is valid/ready; DUT stream is valid-only (checker never stalls it).
interface llr_stream_checker_if #(
    parameter int LLR_W    = 19,
    parameter int NUM_LANE = 6
);
    logic                      ref_vld;
    logic                      ref_rdy;
    logic [NUM_LANE*LLR_W-1:0] ref_dat;
    logic                      dut_vld;
    logic [NUM_LANE*LLR_W-1:0] dut_dat;

    // Source side: drives both streams, observes ref backpressure.
    modport master (
        output ref_vld,
        input  ref_rdy,
        output ref_dat,
        output dut_vld,
        output dut_dat
    );

    // Checker side.
    modport slave (
        input  ref_vld,
        output ref_rdy,
        input  ref_dat,
        input  dut_vld,
        input  dut_dat
    );
endinterface

// File: rtl/llr_stream_checker.sv
// Purpose: compares demapper LLR lanes against a FIFO-buffered reference stream, per-mode counters, first-mismatch capture.
// Latency: compare result and counters update 1 cycle after the DUT word is popped.
// Backpressure: ref_rdy drops when the FIFO is full (unless a pop frees a slot that cycle), during FLUSH and when en=0.
module llr_stream_checker #(
    parameter int          LLR_W     = 19,
    parameter int          NUM_LANE  = 6,
    parameter int          NUM_MODE  = 5,
    parameter int          CNT_W     = 16,
    parameter int          REF_DEPTH = 16,
    parameter int unsigned TOL       = 0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      en,
    input  logic [2:0]                i_mode,
    input  logic                      i_clear,
    llr_stream_checker_if.slave       s_if,
    output logic                      o_cmp_valid,
    output logic                      o_pass,
    output logic [NUM_LANE-1:0]       o_lane_ok,
    output logic [CNT_W-1:0]          o_sym_idx,
    output logic [NUM_MODE*CNT_W-1:0] o_total_cnt,
    output logic [NUM_MODE*CNT_W-1:0] o_correct_cnt,
    output logic                      o_underflow,
    output logic                      o_err_vld,
    output logic [CNT_W-1:0]          o_err_idx,
    output logic [2:0]                o_err_mode
);
    localparam int               AW        = $clog2(REF_DEPTH);
    localparam int               DW        = NUM_LANE * LLR_W;
    localparam logic [1:0]       ST_IDLE   = 2'd0;
    localparam logic [1:0]       ST_RUN    = 2'd1;
    localparam logic [1:0]       ST_FLUSH  = 2'd2;
    localparam logic [AW:0]      FIFO_FULL = (AW+1)'(REF_DEPTH);
    localparam logic [LLR_W:0]   TOL_V     = (LLR_W+1)'(TOL);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    logic [1:0]          state_q, state_d;
    logic [2:0]          run_mode_q, run_mode_d;
    logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [AW:0]         count_q, count_d;
    logic [CNT_W-1:0]    sym_cnt_q, sym_cnt_d;
    logic                cmp_vld_q, cmp_vld_d;
    logic                pass_q, pass_d;
    logic [NUM_LANE-1:0] lane_ok_q, lane_ok_d;
    logic [CNT_W-1:0]    sym_idx_q, sym_idx_d;
    logic [CNT_W-1:0]    total_q [NUM_MODE];
    logic [CNT_W-1:0]    total_d [NUM_MODE];
    logic [CNT_W-1:0]    correct_q [NUM_MODE];
    logic [CNT_W-1:0]    correct_d [NUM_MODE];
    logic                underflow_q, underflow_d;
    logic                err_vld_q, err_vld_d;
    logic [CNT_W-1:0]    err_idx_q, err_idx_d;
    logic [2:0]          err_mode_q, err_mode_d;

    logic [DW-1:0]       mem_q [REF_DEPTH];
    logic [DW-1:0]       rd_dat;
    logic                mode_legal;
    logic                fifo_empty;
    logic                fifo_full;
    logic                pop;
    logic                push;
    logic                ref_rdy;
    logic                underflow_hit;
    logic [NUM_LANE-1:0] lane_res;
    logic                pass_now;

    // Modes above NUM_MODE are treated exactly like idle.
    assign mode_legal    = (i_mode != 3'd0) && (int'(i_mode) <= NUM_MODE);
    assign fifo_empty    = (count_q == '0);
    assign fifo_full     = (count_q == FIFO_FULL);
    assign pop           = en && (state_q == ST_RUN) && s_if.dut_vld && !fifo_empty;
    assign underflow_hit = en && (state_q == ST_RUN) && s_if.dut_vld && fifo_empty;
    // A pop in the same cycle frees a slot, so a full FIFO can still accept.
    assign ref_rdy       = en && (state_q != ST_FLUSH) && (!fifo_full || pop);
    assign push          = s_if.ref_vld && ref_rdy;
    assign s_if.ref_rdy  = ref_rdy;
    assign rd_dat        = mem_q[rd_ptr_q];

    // Per-lane signed compare; difference kept at LLR_W+1 bits so extremes never wrap.
    for (genvar k = 0; k < NUM_LANE; k++) begin : g_lane
        logic [LLR_W-1:0] ref_l;
        logic [LLR_W-1:0] dut_l;
        logic [LLR_W:0]   diff;
        logic [LLR_W:0]   mag;
        logic             act;
        assign ref_l       = rd_dat[(NUM_LANE-1-k)*LLR_W +: LLR_W];
        assign dut_l       = s_if.dut_dat[(NUM_LANE-1-k)*LLR_W +: LLR_W];
        assign diff        = {dut_l[LLR_W-1], dut_l} - {ref_l[LLR_W-1], ref_l};
        assign mag         = diff[LLR_W] ? (~diff + 1'b1) : diff;
        assign act         = (k <= int'(run_mode_q));
        assign lane_res[k] = !act || (mag <= TOL_V);
    end
    assign pass_now = &lane_res;

    // Mode 1 counters sit in the LSBs of the packed outputs.
    for (genvar m = 0; m < NUM_MODE; m++) begin : g_cnt_out
        assign o_total_cnt[m*CNT_W +: CNT_W]   = total_q[m];
        assign o_correct_cnt[m*CNT_W +: CNT_W] = correct_q[m];
    end

    assign o_cmp_valid = cmp_vld_q && en;
    assign o_pass      = pass_q;
    assign o_lane_ok   = lane_ok_q;
    assign o_sym_idx   = sym_idx_q;
    assign o_underflow = underflow_q;
    assign o_err_vld   = err_vld_q;
    assign o_err_idx   = err_idx_q;
    assign o_err_mode  = err_mode_q;

    // Reference word storage; contents need no reset since the pointers define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= s_if.ref_dat;
        end
    end

    // Next-state: FSM, FIFO pointers, compare registers, counters and error capture.
    always_comb begin
        state_d     = state_q;
        run_mode_d  = run_mode_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        sym_cnt_d   = sym_cnt_q;
        cmp_vld_d   = 1'b0;
        pass_d      = pass_q;
        lane_ok_d   = lane_ok_q;
        sym_idx_d   = sym_idx_q;
        total_d     = total_q;
        correct_d   = correct_q;
        underflow_d = underflow_q;
        err_vld_d   = err_vld_q;
        err_idx_d   = err_idx_q;
        err_mode_d  = err_mode_q;

        if (en) begin
            case (state_q)
                ST_IDLE: begin
                    if (mode_legal) begin
                        state_d    = ST_RUN;
                        run_mode_d = i_mode;
                    end
                end
                ST_RUN: begin
                    if (!mode_legal || (i_mode != run_mode_q)) begin
                        state_d = ST_FLUSH;
                    end
                end
                ST_FLUSH: begin
                    if (mode_legal) begin
                        state_d    = ST_RUN;
                        run_mode_d = i_mode;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase

            if (state_q == ST_FLUSH) begin
                wr_ptr_d  = '0;
                rd_ptr_d  = '0;
                count_d   = '0;
                sym_cnt_d = '0;
                sym_idx_d = '0;
            end else begin
                if (push) wr_ptr_d = wr_ptr_q + 1'b1;
                if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
                count_d = count_q + (AW+1)'(push) - (AW+1)'(pop);
            end

            cmp_vld_d = pop;
            if (pop) begin
                pass_d    = pass_now;
                lane_ok_d = lane_res;
                sym_idx_d = sym_cnt_q;
                sym_cnt_d = (sym_cnt_q == CNT_MAX) ? sym_cnt_q : sym_cnt_q + 1'b1;
                for (int m = 0; m < NUM_MODE; m++) begin
                    if (run_mode_q == 3'(m + 1)) begin
                        if (total_q[m] != CNT_MAX) total_d[m] = total_q[m] + 1'b1;
                        if (pass_now && (correct_q[m] != CNT_MAX)) correct_d[m] = correct_q[m] + 1'b1;
                    end
                end
                if (!pass_now && !err_vld_q) begin
                    err_vld_d  = 1'b1;
                    err_idx_d  = sym_cnt_q;
                    err_mode_d = run_mode_q;
                end
            end

            if (underflow_hit) underflow_d = 1'b1;

            // Clear wins over anything counted or captured this cycle.
            if (i_clear) begin
                for (int m = 0; m < NUM_MODE; m++) begin
                    total_d[m]   = '0;
                    correct_d[m] = '0;
                end
                underflow_d = 1'b0;
                err_vld_d   = 1'b0;
                err_idx_d   = '0;
                err_mode_d  = '0;
            end
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            run_mode_q  <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            sym_cnt_q   <= '0;
            cmp_vld_q   <= 1'b0;
            pass_q      <= 1'b0;
            lane_ok_q   <= '0;
            sym_idx_q   <= '0;
            for (int m = 0; m < NUM_MODE; m++) begin
                total_q[m]   <= '0;
                correct_q[m] <= '0;
            end
            underflow_q <= 1'b0;
            err_vld_q   <= 1'b0;
            err_idx_q   <= '0;
            err_mode_q  <= '0;
        end else begin
            state_q     <= state_d;
            run_mode_q  <= run_mode_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            sym_cnt_q   <= sym_cnt_d;
            cmp_vld_q   <= cmp_vld_d;
            pass_q      <= pass_d;
            lane_ok_q   <= lane_ok_d;
            sym_idx_q   <= sym_idx_d;
            total_q     <= total_d;
            correct_q   <= correct_d;
            underflow_q <= underflow_d;
            err_vld_q   <= err_vld_d;
            err_idx_q   <= err_idx_d;
            err_mode_q  <= err_mode_d;
        end
    end
endmodule
